// File: rtl/morse_encoder.sv
// morse_encoder: plays one character code out as timed International Morse
// marks and spaces on a single LED/buzzer line. It also latches the
// character's {pattern, length} symbol word so the word can be looped into
// the decoder path.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   start        request to send char_code (sampled on clk)
//   char_code    0-9 digits, 10-35 'A'-'Z', 36 word space, 37-63 invalid
//   morse_out    1 = mark (tone/LED on), registered
//   busy         a character (or word space) is in progress
//   done         one-cycle pulse when a character or space finishes
//   err          one-cycle pulse when an idle start presents an invalid code
//   sym_pattern  right-aligned pattern of the last accepted character
//                (dot = 0, dash = 1, bit [sym_len-1] is sent first)
//   sym_len      symbol count of the last accepted character (0 for space)
//
// States:
//   IDLE | waiting for start
//   MARK | morse_out high for one dot (1 unit) or one dash (3 units)
//   GAP  | 1-unit off time between symbols of the same character
//   TAIL | 3-unit trailing gap, or 7-unit word space

module morse_encoder #(
    parameter int UNIT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] char_code,
    output logic       morse_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [4:0] sym_pattern,
    output logic [2:0] sym_len
);

    localparam int CNT_W = $clog2(7 * UNIT_CYCLES + 1);

    // The counter is loaded with duration-1 and the state advances on the
    // edge that sees it at zero, so each phase lasts exactly "duration" cycles.
    localparam logic [CNT_W-1:0] DOT_LOAD   = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LOAD  = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPACE_LOAD = CNT_W'(7 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MARK, GAP, TAIL} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;

    logic [4:0] lut_pattern;
    logic [2:0] lut_len;
    logic [2:0] lut_first;
    logic       code_char;
    logic       code_space;

    always_comb begin
        lut_pattern = 5'b00000;
        lut_len     = 3'd0;
        case (char_code)
            6'd0:  {lut_pattern, lut_len} = {5'b11111, 3'd5};
            6'd1:  {lut_pattern, lut_len} = {5'b01111, 3'd5};
            6'd2:  {lut_pattern, lut_len} = {5'b00111, 3'd5};
            6'd3:  {lut_pattern, lut_len} = {5'b00011, 3'd5};
            6'd4:  {lut_pattern, lut_len} = {5'b00001, 3'd5};
            6'd5:  {lut_pattern, lut_len} = {5'b00000, 3'd5};
            6'd6:  {lut_pattern, lut_len} = {5'b10000, 3'd5};
            6'd7:  {lut_pattern, lut_len} = {5'b11000, 3'd5};
            6'd8:  {lut_pattern, lut_len} = {5'b11100, 3'd5};
            6'd9:  {lut_pattern, lut_len} = {5'b11110, 3'd5};
            6'd10: {lut_pattern, lut_len} = {5'b00001, 3'd2}; // A .-
            6'd11: {lut_pattern, lut_len} = {5'b01000, 3'd4}; // B -...
            6'd12: {lut_pattern, lut_len} = {5'b01010, 3'd4}; // C -.-.
            6'd13: {lut_pattern, lut_len} = {5'b00100, 3'd3}; // D -..
            6'd14: {lut_pattern, lut_len} = {5'b00000, 3'd1}; // E .
            6'd15: {lut_pattern, lut_len} = {5'b00010, 3'd4}; // F ..-.
            6'd16: {lut_pattern, lut_len} = {5'b00110, 3'd3}; // G --.
            6'd17: {lut_pattern, lut_len} = {5'b00000, 3'd4}; // H ....
            6'd18: {lut_pattern, lut_len} = {5'b00000, 3'd2}; // I ..
            6'd19: {lut_pattern, lut_len} = {5'b00111, 3'd4}; // J .---
            6'd20: {lut_pattern, lut_len} = {5'b00101, 3'd3}; // K -.-
            6'd21: {lut_pattern, lut_len} = {5'b00100, 3'd4}; // L .-..
            6'd22: {lut_pattern, lut_len} = {5'b00011, 3'd2}; // M --
            6'd23: {lut_pattern, lut_len} = {5'b00010, 3'd2}; // N -.
            6'd24: {lut_pattern, lut_len} = {5'b00111, 3'd3}; // O ---
            6'd25: {lut_pattern, lut_len} = {5'b00110, 3'd4}; // P .--.
            6'd26: {lut_pattern, lut_len} = {5'b01101, 3'd4}; // Q --.-
            6'd27: {lut_pattern, lut_len} = {5'b00010, 3'd3}; // R .-.
            6'd28: {lut_pattern, lut_len} = {5'b00000, 3'd3}; // S ...
            6'd29: {lut_pattern, lut_len} = {5'b00001, 3'd1}; // T -
            6'd30: {lut_pattern, lut_len} = {5'b00001, 3'd3}; // U ..-
            6'd31: {lut_pattern, lut_len} = {5'b00001, 3'd4}; // V ...-
            6'd32: {lut_pattern, lut_len} = {5'b00011, 3'd3}; // W .--
            6'd33: {lut_pattern, lut_len} = {5'b01001, 3'd4}; // X -..-
            6'd34: {lut_pattern, lut_len} = {5'b01011, 3'd4}; // Y -.--
            6'd35: {lut_pattern, lut_len} = {5'b01100, 3'd4}; // Z --..
            default: begin
                lut_pattern = 5'b00000;
                lut_len     = 3'd0;
            end
        endcase
    end

    assign code_char  = (char_code <= 6'd35);
    assign code_space = (char_code == 6'd36);
    assign lut_first  = lut_len - 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= 3'd0;
            morse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            sym_pattern <= 5'b00000;
            sym_len     <= 3'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (code_char) begin
                            sym_pattern <= lut_pattern;
                            sym_len     <= lut_len;
                            idx         <= lut_first;
                            cnt         <= lut_pattern[lut_first] ? DASH_LOAD : DOT_LOAD;
                            morse_out   <= 1'b1;
                            busy        <= 1'b1;
                            state       <= MARK;
                        end else if (code_space) begin
                            sym_pattern <= 5'b00000;
                            sym_len     <= 3'd0;
                            idx         <= 3'd0;
                            cnt         <= SPACE_LOAD;
                            busy        <= 1'b1;
                            state       <= TAIL;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (cnt == '0) begin
                        morse_out <= 1'b0;
                        if (idx != 3'd0) begin
                            // idx now points at the symbol sent after the gap
                            idx   <= idx - 3'd1;
                            cnt   <= DOT_LOAD;
                            state <= GAP;
                        end else begin
                            cnt   <= DASH_LOAD;
                            state <= TAIL;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        morse_out <= 1'b1;
                        cnt       <= sym_pattern[idx] ? DASH_LOAD : DOT_LOAD;
                        state     <= MARK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TAIL: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    morse_out <= 1'b0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: table-driven plus randomized checking of morse_encoder
// with UNIT_CYCLES = 4. The reference model builds the expected waveform
// from dot/dash strings of International Morse.

module tb_morse_encoder;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] char_code;
    logic       morse_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] sym_pattern;
    logic [2:0] sym_len;

    morse_encoder #(.UNIT_CYCLES(U)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .char_code   (char_code),
        .morse_out   (morse_out),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .sym_pattern (sym_pattern),
        .sym_len     (sym_len)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    string mtab [0:35] = '{
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----.",
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."
    };

    bit         wave_q[$];
    logic [4:0] m_pat;
    logic [2:0] m_len;
    logic [4:0] last_pat = 5'b0;
    logic [2:0] last_len = 3'd0;

    typedef struct {
        logic [5:0] code;
        logic [4:0] pat;
        logic [2:0] len;
        int         busy_cycles;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Expected symbol word and per-cycle morse_out for one code.
    task automatic build_model(input int code);
        string s;
        byte   ch;
        int    units;
        wave_q.delete();
        m_pat = 5'b0;
        m_len = 3'd0;
        if (code == 36) begin
            repeat (7 * U) wave_q.push_back(1'b0);
        end else begin
            s     = mtab[code];
            m_len = 3'(s.len());
            for (int i = 0; i < s.len(); i++) begin
                ch    = s[i];
                m_pat = {m_pat[3:0], (ch == "-")};
                units = (ch == "-") ? 3 : 1;
                repeat (units * U) wave_q.push_back(1'b1);
                if (i != s.len() - 1) repeat (U) wave_q.push_back(1'b0);
            end
            repeat (3 * U) wave_q.push_back(1'b0);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic send(input logic [5:0] code, input bit use_tab,
                        input logic [4:0] t_pat, input logic [2:0] t_len,
                        input int t_busy, input bit inject, input string nm);
        int n, mism, stray;
        build_model(code);
        start     = 1'b1;
        char_code = code;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        mism  = 0;
        stray = 0;
        while (busy && n < 400) begin
            if (n >= wave_q.size() || morse_out !== wave_q[n]) mism++;
            if (done || err) stray++;
            if (inject && n == 5) begin
                start     = 1'b1;
                char_code = 6'd14;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        chk({nm, " busy_len"}, n, wave_q.size());
        if (use_tab) chk({nm, " busy_len_tab"}, n, t_busy);
        chk({nm, " wave_mismatches"}, mism, 0);
        chk({nm, " stray_done_err"}, stray, 0);
        chk({nm, " done_pulse"}, int'(done), 1);
        chk({nm, " sym_pattern"}, int'(sym_pattern), int'(m_pat));
        chk({nm, " sym_len"}, int'(sym_len), int'(m_len));
        if (use_tab) begin
            chk({nm, " sym_pattern_tab"}, int'(sym_pattern), int'(t_pat));
            chk({nm, " sym_len_tab"}, int'(sym_len), int'(t_len));
        end
        last_pat = m_pat;
        last_len = m_len;
    endtask

    task automatic send_invalid(input logic [5:0] code);
        start     = 1'b1;
        char_code = code;
        @(negedge clk);
        start = 1'b0;
        chk("invalid err", int'(err), 1);
        chk("invalid busy", int'(busy), 0);
        chk("invalid done", int'(done), 0);
        chk("invalid sym_pattern", int'(sym_pattern), int'(last_pat));
        chk("invalid sym_len", int'(sym_len), int'(last_len));
        @(negedge clk);
        chk("invalid err_one_cycle", int'(err), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt;
        logic [5:0] rc;

        vecs[0] = '{6'd14, 5'b00000, 3'd1, 16};
        vecs[1] = '{6'd10, 5'b00001, 3'd2, 32};
        vecs[2] = '{6'd0,  5'b11111, 3'd5, 88};
        vecs[3] = '{6'd29, 5'b00001, 3'd1, 24};
        vecs[4] = '{6'd23, 5'b00010, 3'd2, 32};
        vecs[5] = '{6'd26, 5'b01101, 3'd4, 64};
        vecs[6] = '{6'd1,  5'b01111, 3'd5, 80};
        vecs[7] = '{6'd5,  5'b00000, 3'd5, 48};
        vecs[8] = '{6'd6,  5'b10000, 3'd5, 56};
        vecs[9] = '{6'd36, 5'b00000, 3'd0, 28};

        rst       = 1'b1;
        start     = 1'b0;
        char_code = 6'd0;
        #3;
        chk("reset outputs", int'({morse_out, busy, done, err, sym_pattern, sym_len}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            send(vecs[i].code, 1'b1, vecs[i].pat, vecs[i].len,
                 vecs[i].busy_cycles, 1'b0, $sformatf("tab%0d", i));

        // Space then invalid 40 while idle.
        @(negedge clk);
        send(6'd36, 1'b1, 5'b0, 3'd0, 28, 1'b0, "space");
        @(negedge clk);
        send_invalid(6'd40);

        // T with an ignored mid-busy start, then E started in the done cycle.
        send(6'd29, 1'b1, 5'b00001, 3'd1, 24, 1'b1, "t_inject");
        send(6'd14, 1'b1, 5'b00000, 3'd1, 16, 1'b0, "e_back2back");

        // Reset in the middle of A's dash.
        @(negedge clk);
        start     = 1'b1;
        char_code = 6'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_dash morse_out", int'(morse_out), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset outputs", int'({morse_out, busy, done, err, sym_pattern, sym_len}), 0);
        @(negedge clk);
        rst      = 1'b0;
        last_pat = 5'b0;
        last_len = 3'd0;
        hi_cnt   = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy || morse_out) hi_cnt++;
        end
        chk("after_reset quiet", hi_cnt, 0);
        send(6'd23, 1'b1, 5'b00010, 3'd2, 32, 1'b0, "n_after_reset");

        // Sweep every valid code against the model.
        for (int c = 0; c <= 36; c++) begin
            @(negedge clk);
            send(6'(c), 1'b0, 5'b0, 3'd0, 0, 1'b0, $sformatf("sweep%0d", c));
        end

        // Random codes, random idle gaps, random invalid starts.
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) send_invalid(6'($urandom_range(37, 63)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rc = 6'($urandom_range(0, 36));
            send(rc, 1'b0, 5'b0, 3'd0, 0, 1'b0, $sformatf("rand%0d_code%0d", i, rc));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
- Transmit-side counterpart of the Morse display translator.
- Accepts one character code per handshake and plays it out as timed Morse marks and spaces on a single LED/buzzer line.
- Also presents the character's {pattern, length} symbol word. This lets a bench or board loop it straight into the decoder path for self-test.
- Sits between the character-select logic (switches/keypad) and the LED/buzzer pin.

Parameters:
- UNIT_CYCLES, 5000000: clock cycles per Morse time unit (50 ms at 100 MHz). Must be ≥2.
- CNT_W, $clog2(7*UNIT_CYCLES+1): duration counter width. Derived localparam; not overridable.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to send char_code; sampled on clk
- char_code  input  6  0-9 = digits '0'-'9'; 10-35 = 'A'-'Z'; 36 = word space; 37-63 invalid
- morse_out  output  1  1 = mark (tone/LED on)
- busy  output  1  character in progress
- done  output  1  one-cycle pulse when a character (or space) finishes
- err  output  1  one-cycle pulse when start presents an invalid code
- sym_pattern  output  5  latched pattern of the last accepted character
- sym_len  output  3  latched symbol count (1-5) of the last accepted character

Behaviour:
- Reset: asynchronous, takes effect immediately. Every output is 0, state is IDLE, counter is 0. Reset mid-character aborts it with no done pulse.
- Symbol encoding (International Morse):
  - dot = 0, dash = 1.
  - Pattern is right-aligned in sym_pattern. Bit [sym_len-1] is the first symbol sent; unused upper bits are 0.
  - Examples: E = 00000/1, T = 00001/1, A = 00001/2, N = 00010/2, Q = 01101/4, 1 = 01111/5, 5 = 00000/5, 6 = 10000/5, 0 = 11111/5.
  - The table must be bit-identical to the encoding the display translator consumes.
- Space (code 36): sym_pattern = 0, sym_len = 0.
- Timing: dot mark = 1 unit; dash mark = 3 units; gap between symbols = 1 unit off; trailing gap after the last symbol = 3 units off; word space = 7 units off, no mark.
- States: IDLE, MARK, GAP, TAIL.
- IDLE:
  - A start with a valid code is accepted on that edge. sym_pattern, sym_len and the symbol index (sym_len-1) are latched, and busy is set to 1.
  - Letters/digits go to MARK with morse_out = 1 from that edge.
  - Space goes directly to TAIL with a 7-unit count.
  - A start with an invalid code pulses err for one cycle. busy, sym_* and state are unchanged.
- MARK: runs UNIT_CYCLES or 3*UNIT_CYCLES cycles, then morse_out = 0.
  - If the index is > 0: go to GAP (UNIT_CYCLES) and decrement the index.
  - Otherwise: go to TAIL (3*UNIT_CYCLES).
- GAP: on expiry, go to MARK for the next symbol.
- TAIL: on expiry, go to IDLE with busy = 0 and done = 1 for exactly one cycle.
- Latency: morse_out rises in the first cycle after the accepting edge. Total busy cycles = sum of marks + gaps + tail, counted in units × UNIT_CYCLES.
- start while busy = 1 is ignored: no queueing, no err.
- start in the done cycle is accepted, giving back-to-back characters with no extra idle cycle.
- morse_out is registered and glitch-free. It is never 1 outside MARK.

Test Plan (UNIT_CYCLES = 4; start pulse sampled at edge 0):
- 'E' (14): morse_out high 4 cycles, then low. busy high 16 cycles. done high in cycle 16 only. sym_pattern = 00000, sym_len = 1.
- 'A' (10): morse_out sequence is 4 high, 4 low, 12 high, then low. busy = 32 cycles. done at cycle 32. sym = 00001/2.
- '0' (0): five 12-cycle marks separated by 4-cycle gaps, then a 12-cycle tail. busy = 88 cycles. sym = 11111/5.
- Space (36), then invalid code 40 while idle: space gives busy 28 cycles with morse_out never high and done at 28. Code 40 gives err for 1 cycle with busy, done and sym_* unchanged.
- 'T' (29) sent, start with 'E' during busy, then 'E' again in the done cycle: the mid-busy start is ignored. The second 'E' mark starts the cycle after done. Loopback sym = 00000/1 decodes to 'E'.
- Reset asserted mid-dash of 'A': outputs drop to 0 asynchronously and no done pulse follows. After release, 'N' (23) transmits 12 high, 4 low, 4 high, 12-cycle tail.
